ram_tester: RTL and testbench
=============================

RAM_TESTER -- requirements
Module: ram_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width (depth = 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles (range 1..4).
REQ-004 SHALL have parameter STEP, default 128, seed increment per pass (mod 2**DATA_W).
REQ-005 SHALL have parameter NUM_PASSES, default 0, pass count (0 = run until stop).
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-009 SHALL have port stop  input  1  request to end the run after the current pass.
REQ-010 SHALL have port wren  output  1  RAM write enable.
REQ-011 SHALL have port addr  output  ADDR_W  RAM address.
REQ-012 SHALL have port wdata  output  DATA_W  RAM write data.
REQ-013 SHALL have port rdata  input  DATA_W  RAM read data, valid RD_LAT cycles after addr.
REQ-014 SHALL have port busy  output  1  high while a run is active.
REQ-015 SHALL have port done  output  1  one-cycle pulse at the end of a run.
REQ-016 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-017 SHALL have port err_cnt  output  16  saturating mismatch count.
REQ-018 SHALL have port fail_addr  output  ADDR_W  address of the first mismatch of the run.

Function
REQ-019 SHALL implement the states IDLE, WRITE, READ, DRAIN and DONE.
REQ-020 IDLE SHALL move to WRITE on start; it SHALL clear err_cnt and fail_addr and set seed to 0.
REQ-021 WRITE SHALL issue one write per cycle: wren=1, addr 0..2**ADDR_W-1, wdata = seed+addr (mod 2**DATA_W).
REQ-022 After the last address, WRITE SHALL move to READ with wren=0 and addr=0.
REQ-023 READ SHALL issue one address per cycle with wren=0.
REQ-024 For each issued read, expected data and address SHALL be delayed RD_LAT cycles and compared to rdata.
REQ-025 A mismatch SHALL increment err_cnt, saturating at 16'hFFFF.
REQ-026 fail_addr SHALL latch only when err_cnt is 0 at the time of the mismatch.
REQ-027 After the last read address, the block SHALL enter DRAIN for exactly RD_LAT cycles and keep comparing.
REQ-028 At the end of DRAIN, seed SHALL be set to seed+STEP.
REQ-029 At the end of DRAIN, the block SHALL go to DONE if stop has been seen or the pass count equals NUM_PASSES (when NUM_PASSES is nonzero); otherwise it SHALL go to WRITE.
REQ-030 stop SHALL be sticky while busy; start SHALL be ignored while busy.
REQ-031 DONE SHALL pulse done for one cycle, update pass = (err_cnt==0) and return to IDLE.
REQ-032 pass, err_cnt and fail_addr SHALL hold their values until the next start.
REQ-033 busy SHALL be 1 in WRITE, READ and DRAIN, and 0 in IDLE and DONE.
REQ-034 Address counters SHALL wrap only at the phase transition and SHALL never exceed 2**ADDR_W-1.

Reset
REQ-035 While rst is high, state SHALL be IDLE, and wren, addr, wdata, busy, done, pass, err_cnt, fail_addr, seed, the pass counter and the delay line SHALL all be 0.
REQ-036 Reset asserted mid-run SHALL abort the run immediately, with no done pulse and all compare results discarded.

Configuration
REQ-037 With RAM_TESTER_STOP_ON_ERR_EN defined, the first mismatch SHALL force DONE on the next cycle (pass=0, err_cnt=1, fail_addr latched), and in-flight reads SHALL be discarded.
REQ-038 Without RAM_TESTER_STOP_ON_ERR_EN, mismatches SHALL only be counted and the run SHALL continue per REQ-029.

Structure
REQ-039 Package ram_tester_pkg SHALL hold the state enum typedef, ERR_W=16 and ERR_MAX.
REQ-040 Sub-module ram_tester_dly SHALL implement the RD_LAT-deep valid/expected/address delay line.

Verification
REQ-041 Default parameters, RAM model RD_LAT=1, NUM_PASSES=2, start -> 256 writes with data 0..255, 256 reads, then seed 128 writes data 128..255,0..127; done after pass 2, pass=1, err_cnt=0.
REQ-042 Model corrupts addr 8'h05 on read -> err_cnt=1, fail_addr=8'h05, pass=0.
REQ-043 RD_LAT=3 with a matching model, NUM_PASSES=1 -> DRAIN lasts 3 cycles, err_cnt=0, done exactly 3 cycles after the last read address plus one.
REQ-044 NUM_PASSES=0, stop pulsed mid-WRITE of pass 1 -> run finishes pass 1 then DONE; start while busy has no effect.
REQ-045 rst asserted during READ -> all outputs 0 in the same cycle, no done pulse; a later start runs a clean pass.
REQ-046 With RAM_TESTER_STOP_ON_ERR_EN defined and corrupt addr 8'h10 -> DONE follows, err_cnt=1, fail_addr=8'h10, no further reads issued.

Source files
------------

// File: rtl/ram_tester_pkg.sv
// ram_tester_pkg -- shared types and constants for the RAM tester.
//   state_e : FSM state encoding (IDLE, WRITE, READ, DRAIN, DONE)
//   ERR_W   : width of the mismatch counter
//   ERR_MAX : saturation value of the mismatch counter
//   sat_inc : saturating increment of the mismatch counter
package ram_tester_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int              ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/ram_tester_dly.sv
// ram_tester_dly -- RD_LAT-deep delay line carrying the read-valid flag, the
// expected data and the address of each issued read, so that they line up
// with the RAM's rdata.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : drop everything in flight, including the current input
//   in_valid/exp/addr  : read issued this cycle
//   out_valid/exp/addr : same read, RD_LAT cycles later
module ram_tester_dly #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_exp,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_exp,
    output logic [ADDR_W-1:0] out_addr
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] exp_q [RD_LAT];
    logic [ADDR_W-1:0] adr_q [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                exp_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid && !flush;
            exp_q[0] <= in_exp;
            adr_q[0] <= in_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush;
                exp_q[i] <= exp_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_exp   = exp_q[RD_LAT-1];
    assign out_addr  = adr_q[RD_LAT-1];

endmodule

// File: rtl/ram_tester.sv
// ram_tester -- march-style RAM tester. Each pass writes seed+addr to every
// address, reads every address back and compares against the same pattern,
// then advances the seed by STEP.
// Optional feature: define RAM_TESTER_STOP_ON_ERR_EN to end the run on the
// first mismatch.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start, stop    : run requests (see below)
//   wren/addr/wdata: RAM write/address bus, rdata: RAM read data (RD_LAT later)
//   busy, done     : run active / one-cycle end-of-run pulse
//   pass, err_cnt, fail_addr : results of the last run
//   state_dbg      : current FSM state
// Request semantics: start is a single-cycle request honoured only in IDLE;
// stop is sampled every busy cycle and remembered until the current pass
// ends. There is no back-pressure on the RAM side: one access per cycle.
module ram_tester
    import ram_tester_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STEP       = 128,
    parameter int NUM_PASSES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              wren,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output state_e            state_dbg
);

    localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);
`ifdef RAM_TESTER_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] seed_q;
    logic [2:0]        drain_q;
    logic [15:0]       pass_cnt_q;
    logic              stop_seen_q;
    logic [ERR_W-1:0]  err_q, err_nxt;
    logic [ADDR_W-1:0] fail_q;
    logic              pass_q;

    logic              dly_valid;
    logic [DATA_W-1:0] dly_exp;
    logic [ADDR_W-1:0] dly_addr;
    logic [DATA_W-1:0] pattern;
    logic              mismatch, abort, last_addr, drain_last, last_pass, enter_done;

    assign pattern    = seed_q + DATA_W'(addr_q);
    assign last_addr  = (addr_q == '1);
    assign drain_last = (drain_q == 3'(RD_LAT - 1));
    assign last_pass  = (NUM_PASSES != 0) && ((pass_cnt_q + 16'd1) == 16'(NUM_PASSES));
    assign mismatch   = dly_valid && (rdata != dly_exp);
    assign abort      = STOP_ON_ERR && mismatch;
    assign err_nxt    = mismatch ? sat_inc(err_q) : err_q;

    ram_tester_dly #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (state == S_READ),
        .in_exp    (pattern),
        .in_addr   (addr_q),
        .out_valid (dly_valid),
        .out_exp   (dly_exp),
        .out_addr  (dly_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WRITE;
            S_WRITE: if (last_addr) state_nxt = S_READ;
            S_READ: begin
                if (abort)          state_nxt = S_DONE;
                else if (last_addr) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort) state_nxt = S_DONE;
                else if (drain_last)
                    state_nxt = (stop_seen_q || stop || last_pass) ? S_DONE : S_WRITE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            seed_q      <= '0;
            drain_q     <= '0;
            pass_cnt_q  <= '0;
            stop_seen_q <= 1'b0;
            err_q       <= '0;
            fail_q      <= '0;
            pass_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= '0;
                        seed_q      <= '0;
                        drain_q     <= '0;
                        pass_cnt_q  <= '0;
                        stop_seen_q <= 1'b0;
                        err_q       <= '0;
                        fail_q      <= '0;
                        pass_q      <= 1'b0;
                    end
                end
                // The natural wrap from all-ones to zero coincides with the
                // phase change, so the counter never leaves the address range.
                S_WRITE: addr_q <= addr_q + ADDR_W'(1);
                S_READ:  addr_q <= abort ? '0 : addr_q + ADDR_W'(1);
                S_DRAIN: begin
                    if (drain_last || abort) begin
                        drain_q <= '0;
                        if (!abort) begin
                            seed_q     <= seed_q + STEP_V;
                            pass_cnt_q <= pass_cnt_q + 16'd1;
                        end
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                default: ;
            endcase

            if (busy && stop) stop_seen_q <= 1'b1;

            if (mismatch) begin
                err_q <= err_nxt;
                if (err_q == '0) fail_q <= dly_addr;
            end

            // Use the count including this cycle's compare so pass is valid
            // together with the done pulse.
            if (enter_done) pass_q <= (err_nxt == '0);
        end
    end

    assign busy      = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign wren      = (state == S_WRITE);
    assign addr      = addr_q;
    assign wdata     = wren ? pattern : '0;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_addr = fail_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_ram_tester.sv
// tb_ram_tester -- bench for ram_tester. Two instances: A (RD_LAT=1,
// NUM_PASSES=2) and B (RD_LAT=3, NUM_PASSES=0), each with its own RAM model.
// A run model expands every start into the full expected bus sequence.
module tb_ram_tester;
    import ram_tester_pkg::*;

`ifdef RAM_TESTER_STOP_ON_ERR_EN
    localparam logic [7:0] CORRUPT_ADDR = 8'h10;
    localparam int         ABORT_AT     = 16;
`else
    localparam logic [7:0] CORRUPT_ADDR = 8'h05;
    localparam int         ABORT_AT     = -1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic a_wren, a_busy, a_done, a_pass, b_wren, b_busy, b_done, b_pass;
    logic [7:0]  a_addr, a_wdata, a_rdata, a_fail, b_addr, b_wdata, b_rdata, b_fail;
    logic [15:0] a_err, b_err;
    state_e a_state, b_state;

    ram_tester #(.RD_LAT(1), .NUM_PASSES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
        .wren(a_wren), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
        .fail_addr(a_fail), .state_dbg(a_state)
    );

    ram_tester #(.RD_LAT(3), .NUM_PASSES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
        .wren(b_wren), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
        .fail_addr(b_fail), .state_dbg(b_state)
    );

    // ---------------- RAM models ----------------
    logic       corrupt_en = 1'b0;
    logic [7:0] mem_a [256];
    logic [7:0] rd_a;
    logic [7:0] mem_b [256];
    logic [7:0] pipe_b [3];

    always @(posedge clk) begin
        if (a_wren) mem_a[a_addr] <= a_wdata;
        rd_a <= (corrupt_en && a_busy && !a_wren && a_addr == CORRUPT_ADDR)
                ? ~mem_a[a_addr] : mem_a[a_addr];
    end
    assign a_rdata = rd_a;

    always @(posedge clk) begin
        if (b_wren) mem_b[b_addr] <= b_wdata;
        pipe_b[0] <= mem_b[b_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_rdata = pipe_b[2];

    // ---------------- observed instance ----------------
    logic        sel = 1'b0;
    logic        m_busy, m_done, m_wren, m_pass;
    logic [7:0]  m_addr, m_wdata, m_fail;
    logic [15:0] m_err;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_wren  = sel ? b_wren  : a_wren;
    assign m_pass  = sel ? b_pass  : a_pass;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_wdata = sel ? b_wdata : a_wdata;
    assign m_fail  = sel ? b_fail  : a_fail;
    assign m_err   = sel ? b_err   : a_err;

    // ---------------- scoreboard ----------------
    // Entry: {busy, done, wren, check_addr, addr[7:0], wdata[7:0]}
    logic [19:0] exp_q[$];
    logic [19:0] cmp_e;
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [19:0] mk(input logic b, input logic d, input logic w,
                                       input logic ca, input logic [7:0] a,
                                       input logic [7:0] wd);
        return {b, d, w, ca, a, wd};
    endfunction

    // One run: per pass 256 writes of seed+addr, 256 reads, lat drain cycles,
    // seed advancing by 128; a single done cycle closes the run. With an
    // abort address the run ends the cycle after its mismatch is seen.
    task automatic build_run(input int lat, input int npass, input int abort_addr);
        logic [7:0] seed;
        seed = 8'd0;
        for (int p = 0; p < npass; p++) begin
            for (int a = 0; a < 256; a++)
                exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'(a), seed + 8'(a)));
            if (abort_addr >= 0) begin
                for (int a = 0; a <= abort_addr + lat; a++)
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'(a), 8'd0));
                break;
            end
            for (int a = 0; a < 256; a++)
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'(a), 8'd0));
            for (int d = 0; d < lat; d++)
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
            seed = seed + 8'd128;
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if ({m_busy, m_done, m_wren, m_pass, m_addr, m_wdata, m_err, m_fail} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got busy=%0b done=%0b wren=%0b pass=%0b addr=%0h wdata=%0h err=%0h fail=%0h, expected all 0",
                         m_busy, m_done, m_wren, m_pass, m_addr, m_wdata, m_err, m_fail);
            end
        end else if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            n_vec++;
            if (m_busy !== cmp_e[19] || m_done !== cmp_e[18] || m_wren !== cmp_e[17] ||
                (cmp_e[16] && m_addr !== cmp_e[15:8]) || (cmp_e[17] && m_wdata !== cmp_e[7:0])) begin
                n_err++;
                $display("FAIL bus_cycle @%0t: got busy=%0b done=%0b wren=%0b addr=%0h wdata=%0h, expected busy=%0b done=%0b wren=%0b addr=%0h(chk %0b) wdata=%0h",
                         $time, m_busy, m_done, m_wren, m_addr, m_wdata,
                         cmp_e[19], cmp_e[18], cmp_e[17], cmp_e[15:8], cmp_e[16], cmp_e[7:0]);
            end
        end else begin
            n_vec++;
            if (m_busy !== 1'b0 || m_done !== 1'b0 || m_wren !== 1'b0) begin
                n_err++;
                $display("FAIL idle_cycle @%0t: got busy=%0b done=%0b wren=%0b, expected 0 0 0",
                         $time, m_busy, m_done, m_wren);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_start(input logic use_b, input int lat, input int npass, input int abort_addr);
        sel = use_b;
        tick();
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        build_run(lat, npass, abort_addr);
    endtask

    task automatic wait_model(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("run_timeout_entries_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t_last, t_done, k;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_a", {a_busy, a_done, a_wren, a_pass, a_addr, a_wdata, a_err, a_fail}, 64'd0);
        check_val("reset_b", {b_busy, b_done, b_wren, b_pass, b_addr, b_wdata, b_err, b_fail}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Two clean passes on A.
        run_start(1'b0, 1, 2, -1);
        check_val("model_len", 64'(exp_q.size()), 64'd1027);
        check_val("model_p2_wr80", 64'(exp_q[641]), 64'(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 8'h00)));
        wait_model(3000);
        check_val("clean_pass", 64'(a_pass), 64'd1);
        check_val("clean_err", 64'(a_err), 64'd0);
        check_val("clean_fail", 64'(a_fail), 64'd0);

        // One corrupted read location; stop keeps it to a single pass.
        corrupt_en = 1'b1;
        run_start(1'b0, 1, 1, ABORT_AT);
        repeat (50) tick();
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        wait_model(2000);
        corrupt_en = 1'b0;
        check_val("corrupt_pass", 64'(a_pass), 64'd0);
        check_val("corrupt_err", 64'(a_err), 64'd1);
        check_val("corrupt_fail", 64'(a_fail), 64'(CORRUPT_ADDR));

        // Reset in the middle of the read phase.
        run_start(1'b0, 1, 2, -1);
        repeat (300) tick();
        rst = 1'b1;
        #1;
        check_val("rst_mid_read", {a_busy, a_done, a_wren, a_pass, a_addr, a_wdata, a_err, a_fail}, 64'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_start(1'b0, 1, 2, -1);
        wait_model(3000);
        check_val("after_rst_pass", 64'(a_pass), 64'd1);
        check_val("after_rst_err", 64'(a_err), 64'd0);

        // B: stop mid-write of pass 1, start while busy ignored, drain timing.
        run_start(1'b1, 3, 1, -1);
        repeat (100) tick();
        stop_b = 1'b1;
        tick();
        stop_b = 1'b0;
        repeat (50) tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        t_last = -1;
        t_done = -1;
        k = 0;
        while (t_done < 0 && k < 2000) begin
            @(negedge clk);
            if (b_busy && !b_wren && b_addr == 8'hFF) t_last = k;
            if (b_done) t_done = k;
            k++;
        end
        check_val("drain_to_done", 64'(t_done - t_last), 64'd4);
        wait_model(1000);
        check_val("b1_pass", 64'(b_pass), 64'd1);
        check_val("b1_err", 64'(b_err), 64'd0);

        // B: stop during the read phase of pass 2.
        run_start(1'b1, 3, 2, -1);
        repeat (800) tick();
        stop_b = 1'b1;
        tick();
        stop_b = 1'b0;
        wait_model(2000);
        check_val("b2_pass", 64'(b_pass), 64'd1);
        check_val("b2_err", 64'(b_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
